// File: rtl/config_pkg.sv
// Core configuration: a user-facing config struct and the elaborated cfg_t
// that every front-end block sizes itself from.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned ILEN;
        int unsigned INSTR_PER_FETCH;
        int unsigned IFU_FQ_DEPTH;
        logic        IFU_FETCHQ_BYPASS_EN;
    } user_cfg_t;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned ILEN;
        int unsigned INSTR_PER_FETCH;
        int unsigned IFU_FQ_DEPTH;
        logic        IFU_FETCHQ_BYPASS_EN;
    } cfg_t;

    localparam user_cfg_t DEFAULT_USER_CFG = '{
        VLEN: 32,
        ILEN: 32,
        INSTR_PER_FETCH: 4,
        IFU_FQ_DEPTH: 8,
        IFU_FETCHQ_BYPASS_EN: 1'b1
    };

    // The fetch queue needs at least two entries to overlap enqueue and dequeue.
    function automatic cfg_t build_config(input user_cfg_t u);
        cfg_t c;
        c.VLEN                 = u.VLEN;
        c.ILEN                 = u.ILEN;
        c.INSTR_PER_FETCH      = u.INSTR_PER_FETCH;
        c.IFU_FQ_DEPTH         = (u.IFU_FQ_DEPTH < 2) ? 2 : u.IFU_FQ_DEPTH;
        c.IFU_FETCHQ_BYPASS_EN = u.IFU_FETCHQ_BYPASS_EN;
        return c;
    endfunction

    function automatic cfg_t with_fetch_queue(input cfg_t base, input int unsigned depth,
                                              input logic bypass_en);
        cfg_t c;
        c                      = base;
        c.IFU_FQ_DEPTH         = (depth < 2) ? 2 : depth;
        c.IFU_FETCHQ_BYPASS_EN = bypass_en;
        return c;
    endfunction

endpackage

// File: rtl/ifu_fetch_queue_pkg.sv
// Shared IFU types: the fetch bundle as stored in the fetch queue and seen by decode.
package ifu_fetch_queue_pkg;
    import config_pkg::*;

    localparam cfg_t        IFU_CFG = build_config(DEFAULT_USER_CFG);
    localparam int unsigned FQ_VLEN = IFU_CFG.VLEN;
    localparam int unsigned FQ_ILEN = IFU_CFG.ILEN;
    localparam int unsigned FQ_N    = IFU_CFG.INSTR_PER_FETCH;

    // instr[0] occupies the least significant bits, matching the flat port layout.
    typedef struct packed {
        logic [FQ_VLEN-1:0]           pc;
        logic [FQ_N-1:0][FQ_ILEN-1:0] instr;
        logic [FQ_N-1:0]              mask;
        logic                         pred_taken;
        logic [FQ_VLEN-1:0]           pred_target;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifu_fetch_queue.sv
// Fetch bundle queue between the IFU and decode, with an optional
// empty-queue bypass that presents the incoming bundle in the same cycle.
module ifu_fetch_queue
    import config_pkg::*;
    import ifu_fetch_queue_pkg::*;
#(
    parameter cfg_t        Cfg       = build_config(DEFAULT_USER_CFG),
    parameter int unsigned DEPTH     = Cfg.IFU_FQ_DEPTH,
    parameter int unsigned N         = Cfg.INSTR_PER_FETCH,
    parameter logic        BYPASS_EN = Cfg.IFU_FETCHQ_BYPASS_EN,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    enq_valid_i,
    output logic                    enq_ready_o,
    input  logic [Cfg.VLEN-1:0]     enq_pc_i,
    input  logic [N*Cfg.ILEN-1:0]   enq_instr_i,
    input  logic [N-1:0]            enq_mask_i,
    input  logic                    enq_pred_taken_i,
    input  logic [Cfg.VLEN-1:0]     enq_pred_target_i,
    output logic                    deq_valid_o,
    input  logic                    deq_ready_i,
    output logic [Cfg.VLEN-1:0]     deq_pc_o,
    output logic [N*Cfg.ILEN-1:0]   deq_instr_o,
    output logic [N-1:0]            deq_mask_o,
    output logic                    deq_pred_taken_o,
    output logic [Cfg.VLEN-1:0]     deq_pred_target_o,
    output logic [CNT_W-1:0]        count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    fetch_entry_t w_enq_entry;
    fetch_entry_t w_head_entry;
    logic         w_empty;
    logic         w_full;
    logic         w_deq_valid;
    logic         w_enq_fire;
    logic         w_deq_fire;
    logic         w_bypass_take;
    logic         w_write;
    logic         w_pop;

    always_comb begin
        w_enq_entry             = '0;
        w_enq_entry.pc          = enq_pc_i;
        w_enq_entry.instr       = enq_instr_i;
        w_enq_entry.mask        = enq_mask_i;
        w_enq_entry.pred_taken  = enq_pred_taken_i;
        w_enq_entry.pred_target = enq_pred_target_i;
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign enq_ready_o = !w_full;
    assign count_o     = r_count;

    // An empty queue only shows a bundle when the bypass can forward the incoming one.
    always_comb begin
        w_deq_valid = 1'b0;
        if (rst_ni && !flush_i) begin
            if (!w_empty) begin
                w_deq_valid = 1'b1;
            end else if (BYPASS_EN) begin
                w_deq_valid = enq_valid_i;
            end
        end
    end

    assign w_head_entry = w_empty ? w_enq_entry : r_mem[r_head];

    assign deq_valid_o       = w_deq_valid;
    assign deq_pc_o          = w_deq_valid ? w_head_entry.pc          : '0;
    assign deq_instr_o       = w_deq_valid ? w_head_entry.instr       : '0;
    assign deq_mask_o        = w_deq_valid ? w_head_entry.mask        : '0;
    assign deq_pred_taken_o  = w_deq_valid ? w_head_entry.pred_taken  : 1'b0;
    assign deq_pred_target_o = w_deq_valid ? w_head_entry.pred_target : '0;

    // A bypass hand-off is a dequeue from an empty queue; it never touches storage.
    assign w_enq_fire    = enq_valid_i && !w_full && !flush_i;
    assign w_deq_fire    = w_deq_valid && deq_ready_i;
    assign w_bypass_take = w_empty && w_deq_fire;
    assign w_write       = w_enq_fire && !w_bypass_take;
    assign w_pop         = w_deq_fire && !w_empty;

    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem[r_tail] <= w_enq_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_tail <= (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue across three queue shapes sharing one stimulus bus.
module tb_ifu_fetch_queue;
    import config_pkg::*;
    import ifu_fetch_queue_pkg::*;

    localparam cfg_t BASE  = build_config(DEFAULT_USER_CFG);
    localparam cfg_t CFG_A = with_fetch_queue(BASE, 4, 1'b1);
    localparam cfg_t CFG_B = with_fetch_queue(BASE, 4, 1'b0);
    localparam cfg_t CFG_C = with_fetch_queue(BASE, 3, 1'b0);
    localparam int   EW    = FETCH_ENTRY_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         enq_valid = 1'b0;
    logic         deq_ready = 1'b0;
    logic [31:0]  enq_pc = '0;
    logic [127:0] enq_instr = '0;
    logic [3:0]   enq_mask = '0;
    logic         enq_pt = 1'b0;
    logic [31:0]  enq_tgt = '0;

    logic a_ready, a_valid, a_pt, b_ready, b_valid, b_pt, c_ready, c_valid, c_pt;
    logic [31:0]  a_pc, a_tgt, b_pc, b_tgt, c_pc, c_tgt;
    logic [127:0] a_instr, b_instr, c_instr;
    logic [3:0]   a_mask, b_mask, c_mask;
    logic [2:0]   a_count, b_count;
    logic [1:0]   c_count;

    int           sel = 0;
    int           cur_depth = 4;
    logic         cur_bypass = 1'b1;
    logic         obs_valid, obs_ready;
    logic [7:0]   obs_count;
    logic [EW-1:0] obs_bundle;

    logic [EW-1:0] exp_q[$];
    int           m_count = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    logic         pushed;

    always #5 clk = ~clk;

    ifu_fetch_queue #(.Cfg(CFG_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .enq_valid_i(enq_valid), .enq_ready_o(a_ready), .enq_pc_i(enq_pc),
        .enq_instr_i(enq_instr), .enq_mask_i(enq_mask), .enq_pred_taken_i(enq_pt),
        .enq_pred_target_i(enq_tgt), .deq_valid_o(a_valid), .deq_ready_i(deq_ready),
        .deq_pc_o(a_pc), .deq_instr_o(a_instr), .deq_mask_o(a_mask),
        .deq_pred_taken_o(a_pt), .deq_pred_target_o(a_tgt), .count_o(a_count)
    );

    ifu_fetch_queue #(.Cfg(CFG_B)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .enq_valid_i(enq_valid), .enq_ready_o(b_ready), .enq_pc_i(enq_pc),
        .enq_instr_i(enq_instr), .enq_mask_i(enq_mask), .enq_pred_taken_i(enq_pt),
        .enq_pred_target_i(enq_tgt), .deq_valid_o(b_valid), .deq_ready_i(deq_ready),
        .deq_pc_o(b_pc), .deq_instr_o(b_instr), .deq_mask_o(b_mask),
        .deq_pred_taken_o(b_pt), .deq_pred_target_o(b_tgt), .count_o(b_count)
    );

    ifu_fetch_queue #(.Cfg(CFG_C)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .enq_valid_i(enq_valid), .enq_ready_o(c_ready), .enq_pc_i(enq_pc),
        .enq_instr_i(enq_instr), .enq_mask_i(enq_mask), .enq_pred_taken_i(enq_pt),
        .enq_pred_target_i(enq_tgt), .deq_valid_o(c_valid), .deq_ready_i(deq_ready),
        .deq_pc_o(c_pc), .deq_instr_o(c_instr), .deq_mask_o(c_mask),
        .deq_pred_taken_o(c_pt), .deq_pred_target_o(c_tgt), .count_o(c_count)
    );

    always_comb begin
        obs_valid  = 1'b0;
        obs_ready  = 1'b0;
        obs_count  = '0;
        obs_bundle = '0;
        case (sel)
            0: begin
                obs_valid  = a_valid;
                obs_ready  = a_ready;
                obs_count  = 8'(a_count);
                obs_bundle = {a_pc, a_instr, a_mask, a_pt, a_tgt};
            end
            1: begin
                obs_valid  = b_valid;
                obs_ready  = b_ready;
                obs_count  = 8'(b_count);
                obs_bundle = {b_pc, b_instr, b_mask, b_pt, b_tgt};
            end
            default: begin
                obs_valid  = c_valid;
                obs_ready  = c_ready;
                obs_count  = 8'(c_count);
                obs_bundle = {c_pc, c_instr, c_mask, c_pt, c_tgt};
            end
        endcase
    end

    function automatic logic [EW-1:0] make_bundle(input logic [31:0] pc);
        logic [127:0] ins;
        for (int i = 0; i < 4; i++) begin
            ins[i*32 +: 32] = pc + 32'(i) * 32'd4 + 32'h0013_0000;
        end
        return {pc, ins, {pc[6:4], 1'b1}, pc[4], pc + 32'h40};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: outputs are checked against the bench model while inputs are stable.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl,
                        output logic did_push);
        logic [EW-1:0] b;
        logic [EW-1:0] e;
        logic          exp_ready;
        logic          exp_valid;
        @(negedge clk);
        b = make_bundle(pc);
        enq_valid = v;
        {enq_pc, enq_instr, enq_mask, enq_pt, enq_tgt} = b;
        deq_ready = rdy;
        flush = fl;
        #1;
        exp_ready = (m_count != cur_depth);
        exp_valid = !fl && (m_count != 0 || (cur_bypass && v));
        check("count", 256'(obs_count), 256'(m_count));
        check("enq_ready", 256'(obs_ready), 256'(exp_ready));
        check("deq_valid", 256'(obs_valid), 256'(exp_valid));
        did_push = v && exp_ready && !fl;
        if (did_push) exp_q.push_back(b);
        if (exp_valid && exp_q.size() != 0) begin
            if (rdy) begin
                e = exp_q.pop_front();
                check("deq_bundle", 256'(obs_bundle), 256'(e));
            end else begin
                check("deq_head", 256'(obs_bundle), 256'(exp_q[0]));
            end
        end else begin
            check("deq_zero", 256'(obs_bundle), 256'(0));
        end
        if (fl) begin
            m_count = 0;
            exp_q.delete();
        end else begin
            m_count = m_count + int'(did_push) - int'(exp_valid && rdy);
        end
        @(posedge clk);
    endtask

    task automatic do_reset(input int s, input int depth, input logic byp);
        rst_n = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush = 1'b0;
        sel = s;
        cur_depth = depth;
        cur_bypass = byp;
        @(negedge clk);
        @(negedge clk);
        check("rst_count", 256'(obs_count), 256'(0));
        check("rst_valid", 256'(obs_valid), 256'(0));
        check("rst_ready", 256'(obs_ready), 256'(1));
        check("rst_data", 256'(obs_bundle), 256'(0));
        rst_n = 1'b1;
        m_count = 0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int cyc;

        // Reset and idle, then bypass hand-off and bypass-with-stall on the 4-deep bypass queue.
        do_reset(0, 4, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, pushed);
        step(1'b1, 32'h8000_0000, 1'b1, 1'b0, pushed);
        step(1'b0, 32'h0, 1'b0, 1'b0, pushed);
        step(1'b1, 32'h8000_0010, 1'b0, 1'b0, pushed);
        step(1'b0, 32'h0, 1'b1, 1'b0, pushed);
        step(1'b0, 32'h0, 1'b0, 1'b0, pushed);

        // Fill to full without bypass, a refused fifth offer, then an in-order drain.
        do_reset(1, 4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'(i) * 32'h10, 1'b0, 1'b0, pushed);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, pushed);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, pushed);
        check("drain_empty", 256'(exp_q.size()), 256'(0));

        // Pointer wrap on a 3-deep queue with a randomly stalling consumer.
        do_reset(2, 3, 1'b0);
        sent = 0;
        cyc = 0;
        while ((sent < 10 || exp_q.size() != 0) && cyc < 200) begin
            step(sent < 10, 32'h1000 + 32'(sent) * 32'h10, 1'($urandom_range(0, 1)), 1'b0, pushed);
            if (pushed) sent++;
            cyc++;
        end
        check("wrap_in_budget", 256'(cyc < 200), 256'(1));
        check("wrap_sent", 256'(sent), 256'(10));

        // Flush with three entries held and a bundle offered in the flush cycle.
        do_reset(0, 4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h500 + 32'(i) * 32'h10, 1'b0, 1'b0, pushed);
        end
        step(1'b1, 32'h5550, 1'b1, 1'b1, pushed);
        step(1'b0, 32'h0, 1'b0, 1'b0, pushed);
        step(1'b1, 32'h600, 1'b1, 1'b0, pushed);
        step(1'b0, 32'h0, 1'b1, 1'b0, pushed);

        // Asynchronous reset in the middle of a burst.
        do_reset(0, 4, 1'b1);
        step(1'b1, 32'h200, 1'b0, 1'b0, pushed);
        step(1'b1, 32'h210, 1'b0, 1'b0, pushed);
        enq_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", 256'(obs_valid), 256'(0));
        check("async_count", 256'(obs_count), 256'(0));
        check("async_ready", 256'(obs_ready), 256'(1));
        m_count = 0;
        exp_q.delete();
        @(negedge clk);
        enq_valid = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 32'h100, 1'b0, 1'b0, pushed);
        step(1'b0, 32'h0, 1'b1, 1'b0, pushed);
        step(1'b0, 32'h0, 1'b0, 1'b0, pushed);
        check("post_reset_empty", 256'(exp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
Fetch queue between the IFU fetch/ICache response path and the decode/rename front end. Buffers whole fetch bundles: PC, INSTR_PER_FETCH instruction words, slot-valid mask and branch prediction. Sized and shaped entirely from the elaborated config_pkg::cfg_t. Provides an optional empty-queue bypass to hide one cycle of fetch latency.

Parameters:
Cfg, config_pkg::cfg_t from build_config on the default user config, full core configuration.
DEPTH, Cfg.IFU_FQ_DEPTH (default 8), number of bundle entries; any value >= 2, power of two not required.
N, Cfg.INSTR_PER_FETCH (default 4), instruction slots per bundle.
BYPASS_EN, Cfg.IFU_FETCHQ_BYPASS_EN (default 1), enables the empty-queue bypass.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk_i  in  1  core clock.
rst_ni  in  1  asynchronous active-low reset.
flush_i  in  1  redirect/flush; discards all contents.
enq_valid_i  in  1  bundle offered by the fetch stage.
enq_ready_o  out  1  queue can accept a bundle.
enq_pc_i  in  Cfg.VLEN  PC of slot 0.
enq_instr_i  in  N*Cfg.ILEN  instruction words; slot 0 in the LSBs.
enq_mask_i  in  N  per-slot valid.
enq_pred_taken_i  in  1  bundle predicted taken.
enq_pred_target_i  in  Cfg.VLEN  predicted target.
deq_valid_o  out  1  head bundle valid.
deq_ready_i  in  1  decode accepts the head bundle.
deq_pc_o, deq_instr_o, deq_mask_o, deq_pred_taken_o, deq_pred_target_o  out  (same widths as enq)  head bundle.
count_o  out  CNT_W  current occupancy.

Behaviour:
- Reset (async, rst_ni=0): head=0, tail=0, count=0. Outputs: deq_valid_o=0, enq_ready_o=1, count_o=0, all deq data outputs 0. Storage array is not reset.
- Handshakes:
  - Enqueue fires on enq_valid_i & enq_ready_o.
  - Dequeue fires on deq_valid_o & deq_ready_i.
  - enq_ready_o = (count != DEPTH). It depends on registered state only and has no combinational path from deq_ready_i.
- Pointer wrap: head and tail increment modulo DEPTH by explicit compare to DEPTH-1. Pointer wrap must not use bit truncation.
- count update: count_next = count + enq_fire - deq_fire (bypass excluded, see below). Never exceeds DEPTH and never underflows.
- Normal path (count>0):
  - deq_valid_o=1 and deq_* are driven from entry[head].
  - Latency from enqueue to visible at head is 1 cycle.
- Bypass (BYPASS_EN=1 and count==0 and flush_i=0):
  - deq_valid_o=enq_valid_i and deq_* are driven combinationally from enq_*.
  - If deq_ready_i=1, the bundle is consumed directly: not written, pointers and count unchanged.
  - If deq_ready_i=0, it is written to entry[tail] as a normal enqueue.
- BYPASS_EN=0 and count==0: deq_valid_o=0.
- When deq_valid_o=0, all deq data outputs are forced to 0.
- Full with a simultaneous dequeue: enq_ready_o=0, so no enqueue that cycle. The freed slot becomes visible the next cycle.
- Simultaneous enqueue and dequeue with 0<count<DEPTH: both fire, count unchanged, both pointers advance.
- flush_i=1 (highest priority after reset):
  - deq_valid_o forced 0 in that cycle.
  - Any enqueue or dequeue in that cycle is ignored.
  - Next cycle: head=tail=0, count=0.
- Reset asserted mid-operation: state clears immediately (async). Queue is empty on the first edge after release.

Decomposition:
- fetch_entry_t is a packed struct {pc, instr[N], mask, pred_taken, pred_target}. It lives in the shared ifu package, parameter-free via config-derived localparams, so decode and the IFU reuse it.
- No sub-module required. Storage is an array of fetch_entry_t inside this block.

Test Plan (DEPTH=4, N=4, VLEN=ILEN=32 unless noted):
1. Reset, then idle -> deq_valid_o=0, enq_ready_o=1, count_o=0, deq_pc_o=0.
2. BYPASS_EN=1, empty, enq pc=0x8000_0000 with deq_ready_i=1 -> same-cycle deq_valid_o=1, deq_pc_o=0x8000_0000; count_o remains 0.
3. BYPASS_EN=0, hold deq_ready_i=0, enqueue pc 0x00,0x10,0x20,0x30 -> count_o=4, enq_ready_o=0. A fifth offer (0x40) is not taken. Then drain -> pcs out in order 0x00,0x10,0x20,0x30.
4. Wrap: with DEPTH=3, 10 bundles, continuous enq+deq, random deq_ready_i -> dequeue order matches enqueue order, count_o never >3.
5. count=3, flush_i=1 with enq_valid_i=1 -> next cycle count_o=0, deq_valid_o=0, and the flushed-cycle bundle never appears.
6. rst_ni pulled low mid-burst (count=2, asynchronous to clk) -> immediately deq_valid_o=0, count_o=0; after release, enq pc=0x100 is the first bundle dequeued.
